stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the stopwatch. Turns one-cycle start/stop, lap and clear button pulses into a run/pause/lap state machine. Drives the enable and clear of the `rtc_timer` 10 ms time base, and counts its `o_basetick` rising edges into a BCD MM:SS.cc elapsed time with a lap-freeze display path. Sits between the debounced button front end and the seven-segment display driver.

## Interface
- `CS_PER_SEC`, default 100: basetick rising edges per second; fixed by the 10 ms basetick period.
- `i_sclk`  in  1: system clock, 100 MHz; same clock as `rtc_timer`.
- `i_reset_n`  in  1: asynchronous, active-low reset.
- `i_start_stop`  in  1: one-cycle pulse, synchronous to `i_sclk`.
- `i_lap`  in  1: one-cycle pulse.
- `i_clear`  in  1: one-cycle pulse.
- `i_basetick`  in  1: `o_basetick` from `rtc_timer`. It toggles every 5 ms, so one rising edge marks each 10 ms. It is synchronous to `i_sclk`.
- `o_timerenb`  out  1: drives `rtc_timer` `i_timerenb`.
- `o_timer_clr_n`  out  1: ANDed with `i_reset_n` to form the `rtc_timer` reset. Active-low.
- `o_running`  out  1: high in RUN and LAP.
- `o_lap_active`  out  1: high in LAP.
- `o_min_tens`, `o_min_ones`, `o_sec_tens`, `o_sec_ones`, `o_cs_tens`, `o_cs_ones`  out  4 each: BCD display digits.
- `o_rollover`  out  1: one-cycle pulse on wrap from 59:59.99 to 00:00.00.

## Operation
- **States:** IDLE, RUN, LAP, PAUSE.
- **Input priority:** `i_clear` > `i_start_stop` > `i_lap`. Lower-priority pulses arriving in the same cycle are discarded.
- **IDLE:**
  - start_stop → RUN.
  - lap and clear are ignored.
- **RUN:**
  - start_stop → PAUSE.
  - lap → LAP; the live count is captured into the lap register in the same clock edge.
  - clear is ignored.
- **LAP:**
  - Counting continues; the display shows the lap register.
  - lap → RUN; the display returns to the live count.
  - start_stop → PAUSE; the display shows the live count.
  - clear is ignored.
- **PAUSE:**
  - start_stop → RUN; the partial timer interval is kept.
  - clear → IDLE.
  - lap is ignored.
- **Tick detection:**
  - `tick = i_basetick & ~bt_q`, where `bt_q` is the registered `i_basetick`.
  - A tick is counted only while the current state is RUN or LAP.
- **Counter:**
  - Chained BCD digits with maxima 9, 9 (centiseconds), 9, 5 (seconds), 9, 5 (minutes).
  - A digit carries to the next only when it is at its maximum and incrementing.
  - Full wrap from 59:59.99 to 00:00.00 pulses `o_rollover` and counting continues.
- **Clear (PAUSE → IDLE):**
  - Live counter and lap register are zeroed.
  - `o_timer_clr_n` is driven low for exactly one cycle.
  - `bt_q` is zeroed.

## Timing
- **Reset values (all outputs, asynchronous):**
  - State IDLE.
  - `o_timerenb` = 0.
  - `o_timer_clr_n` = 1.
  - `o_running` = 0, `o_lap_active` = 0.
  - All digits 0.
  - `o_rollover` = 0.
  - `bt_q` = 0.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **Button latency:** 1 cycle. A pulse sampled at edge k changes state, `o_timerenb`, `o_running` and `o_lap_active` visibly after edge k.
- **Tick latency:** if `i_basetick` is first sampled high at edge k, the count is updated after edge k.
- **Tick coinciding with start_stop in RUN:** the tick is counted and the state goes to PAUSE.
- **Tick coinciding with lap in RUN:** the lap register captures the pre-increment value and the live counter increments.
- **`o_timer_clr_n`:** low during the cycle after the clear edge, then high.
- **`o_rollover`:** high for the single cycle after the wrapping edge.
- **Reset mid-RUN:** immediate return to the reset values above, regardless of phase.

## Structure
- **Package `stopwatch_pkg`:**
  - `sw_state_t` enum (IDLE, RUN, LAP, PAUSE).
  - `bcd_t` = logic [3:0].
  - Constants `BCD9_MAX = 9` and `BCD5_MAX = 5`.
- **Sub-module `bcd_digit_counter`:**
  - Parameter MAX.
  - Inputs: clock, reset, sync clear, inc.
  - Outputs: digit, carry = inc & (digit == MAX).
  - Instantiated six times.
- **Top level:** FSM, tick edge detector, lap register, display mux.

## Test plan
- Reset, then start_stop; drive 150 basetick rising edges → display 00:01.50, `o_timerenb` = 1 and `o_running` = 1 one cycle after the pulse.
- RUN at 00:00.37, lap; 20 ticks → display holds 00:00.37, `o_lap_active` = 1; lap again → display 00:00.57.
- RUN at 00:05.00, start_stop; 10 basetick edges → display stays 00:05.00, `o_timerenb` = 0; clear → all digits 0, `o_timer_clr_n` low for exactly 1 cycle, state IDLE.
- Preload via ticks to 59:59.99, one more tick → 00:00.00, `o_rollover` high for 1 cycle, still RUN.
- Same-cycle events:
  - clear + start_stop in PAUSE → IDLE, count zeroed.
  - start_stop + tick in RUN at 00:00.09 → PAUSE showing 00:00.10.
  - clear in RUN → ignored.
- Assert `i_reset_n` low mid-RUN at 00:12.34 → all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD9_MAX = 4'd9;
    localparam bcd_t BCD5_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the elapsed-time chain: wraps MAX -> 0 and flags carry on that step.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = BCD9_MAX
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output bcd_t o_digit,
    output logic o_carry
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (i_clr) begin
            digit_d = '0;
        end else if (i_inc) begin
            digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign o_digit = digit_q;
    assign o_carry = i_inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap sequencer for the stopwatch: counts basetick rising edges into
// BCD MM:SS.cc and freezes the display on a lap capture.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CS_PER_SEC = 100
) (
    input  logic      i_sclk,
    input  logic      i_reset_n,
    input  logic      i_start_stop,
    input  logic      i_lap,
    input  logic      i_clear,
    input  logic      i_basetick,
    output logic      o_timerenb,
    output logic      o_timer_clr_n,
    output logic      o_running,
    output logic      o_lap_active,
    output bcd_t      o_min_tens,
    output bcd_t      o_min_ones,
    output bcd_t      o_sec_tens,
    output bcd_t      o_sec_ones,
    output bcd_t      o_cs_tens,
    output bcd_t      o_cs_ones,
    output logic      o_rollover,
    output sw_state_t o_dbg_state
);

    localparam bcd_t CS_TENS_MAX = bcd_t'(CS_PER_SEC / 10 - 1);

    sw_state_t       state_q, state_d;
    logic            bt_q, bt_d;
    logic            clr_n_q, clr_n_d;
    logic            roll_q, roll_d;
    logic [5:0][3:0] lap_q, lap_d;
    logic [5:0][3:0] live;
    logic [5:0][3:0] disp;

    logic ev_ss, ev_lap, counting, tick, count_en;
    logic do_clear, do_capture;
    logic carry_cs_ones, carry_cs_tens, carry_sec_ones;
    logic carry_sec_tens, carry_min_ones, carry_min_tens;

    // Clear outranks start_stop, which outranks lap; losers in the same cycle are dropped.
    assign ev_ss    = i_start_stop & ~i_clear;
    assign ev_lap   = i_lap & ~i_start_stop & ~i_clear;
    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = i_basetick & ~bt_q;
    assign count_en = tick & counting;

    always_comb begin
        state_d    = state_q;
        do_clear   = 1'b0;
        do_capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ev_ss) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ev_ss) begin
                    state_d = ST_PAUSE;
                end else if (ev_lap) begin
                    state_d    = ST_LAP;
                    do_capture = 1'b1;
                end
            end
            ST_LAP: begin
                if (ev_ss) state_d = ST_PAUSE;
                else if (ev_lap) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (i_clear) begin
                    state_d  = ST_IDLE;
                    do_clear = 1'b1;
                end else if (ev_ss) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lap capture takes the pre-increment count even when a tick lands on the same edge.
    always_comb begin
        lap_d = lap_q;
        if (do_clear) begin
            lap_d = '0;
        end else if (do_capture) begin
            lap_d = live;
        end
        bt_d    = do_clear ? 1'b0 : i_basetick;
        clr_n_d = ~do_clear;
        roll_d  = carry_min_tens;
    end

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            bt_q    <= 1'b0;
            clr_n_q <= 1'b1;
            roll_q  <= 1'b0;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            bt_q    <= bt_d;
            clr_n_q <= clr_n_d;
            roll_q  <= roll_d;
            lap_q   <= lap_d;
        end
    end

    bcd_digit_counter #(.MAX(BCD9_MAX)) u_cs_ones (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(do_clear), .i_inc(count_en),
        .o_digit(live[0]), .o_carry(carry_cs_ones)
    );
    bcd_digit_counter #(.MAX(CS_TENS_MAX)) u_cs_tens (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(do_clear), .i_inc(carry_cs_ones),
        .o_digit(live[1]), .o_carry(carry_cs_tens)
    );
    bcd_digit_counter #(.MAX(BCD9_MAX)) u_sec_ones (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(do_clear), .i_inc(carry_cs_tens),
        .o_digit(live[2]), .o_carry(carry_sec_ones)
    );
    bcd_digit_counter #(.MAX(BCD5_MAX)) u_sec_tens (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(do_clear), .i_inc(carry_sec_ones),
        .o_digit(live[3]), .o_carry(carry_sec_tens)
    );
    bcd_digit_counter #(.MAX(BCD9_MAX)) u_min_ones (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(do_clear), .i_inc(carry_sec_tens),
        .o_digit(live[4]), .o_carry(carry_min_ones)
    );
    bcd_digit_counter #(.MAX(BCD5_MAX)) u_min_tens (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(do_clear), .i_inc(carry_min_ones),
        .o_digit(live[5]), .o_carry(carry_min_tens)
    );

    assign disp = (state_q == ST_LAP) ? lap_q : live;
    assign {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_cs_tens, o_cs_ones} = disp;

    assign o_timerenb    = counting;
    assign o_running     = counting;
    assign o_lap_active  = (state_q == ST_LAP);
    assign o_timer_clr_n = clr_n_q;
    assign o_rollover    = roll_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: per-cycle output snapshots from a centisecond-integer
// reference model are queued by the driver and compared by an independent monitor.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int W      = 31;
    localparam int WRAP_CS = 360000;
    localparam logic [W-1:0] RESET_VEC = {ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss = 1'b0, lap = 1'b0, clr = 1'b0, bt = 1'b0;
    logic o_timerenb, o_timer_clr_n, o_running, o_lap_active, o_rollover;
    bcd_t o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_cs_tens, o_cs_ones;
    sw_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    sw_state_t m_state;
    int        m_live, m_lap;
    logic      m_bt, m_roll, m_clrn;

    stopwatch_ctrl #(.CS_PER_SEC(100)) dut (
        .i_sclk(clk), .i_reset_n(rst_n), .i_start_stop(ss), .i_lap(lap),
        .i_clear(clr), .i_basetick(bt), .o_timerenb(o_timerenb),
        .o_timer_clr_n(o_timer_clr_n), .o_running(o_running), .o_lap_active(o_lap_active),
        .o_min_tens(o_min_tens), .o_min_ones(o_min_ones), .o_sec_tens(o_sec_tens),
        .o_sec_ones(o_sec_ones), .o_cs_tens(o_cs_tens), .o_cs_ones(o_cs_ones),
        .o_rollover(o_rollover), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] digits(input int c);
        int mm, sc, cs;
        mm = c / 6000;
        sc = (c / 100) % 60;
        cs = c % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic logic [W-1:0] model_vec();
        logic run;
        run = (m_state == ST_RUN) || (m_state == ST_LAP);
        return {m_state, run, m_clrn, run, m_state == ST_LAP,
                digits(m_state == ST_LAP ? m_lap : m_live), m_roll};
    endfunction

    function automatic logic [W-1:0] actual_vec();
        return {dbg_state, o_timerenb, o_timer_clr_n, o_running, o_lap_active,
                o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_cs_tens, o_cs_ones, o_rollover};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE;
        m_live  = 0;
        m_lap   = 0;
        m_bt    = 1'b0;
        m_roll  = 1'b0;
        m_clrn  = 1'b1;
    endtask

    // Stopwatch rules applied to one clock edge, on whole centisecond counts.
    task automatic model_step(input logic s, input logic l, input logic c, input logic b);
        logic tick;
        int   pre;
        tick   = b & ~m_bt;
        pre    = m_live;
        m_roll = 1'b0;
        m_clrn = 1'b1;
        if ((m_state == ST_RUN || m_state == ST_LAP) && tick) begin
            m_live = (m_live + 1) % WRAP_CS;
            m_roll = (m_live == 0);
        end
        m_bt = b;
        if (c) begin
            if (m_state == ST_PAUSE) begin
                m_state = ST_IDLE;
                m_live  = 0;
                m_lap   = 0;
                m_clrn  = 1'b0;
                m_bt    = 1'b0;
            end
        end else if (s) begin
            if (m_state == ST_IDLE || m_state == ST_PAUSE) m_state = ST_RUN;
            else m_state = ST_PAUSE;
        end else if (l) begin
            if (m_state == ST_RUN) begin
                m_lap   = pre;
                m_state = ST_LAP;
            end else if (m_state == ST_LAP) begin
                m_state = ST_RUN;
            end
        end
    endtask

    task automatic step(input logic s, input logic l, input logic c, input logic b);
        @(negedge clk);
        ss  = s;
        lap = l;
        clr = c;
        bt  = b;
        @(posedge clk);
        #1;
        model_step(s, l, c, b);
        exp_q.push_back(model_vec());
        ss  = 1'b0;
        lap = 1'b0;
        clr = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_disp(input string name, input int exp_cs);
        checks++;
        if (actual_vec()[24:1] !== digits(exp_cs)) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, actual_vec()[24:1], digits(exp_cs));
        end
    endtask

    // Loads 59:59.90 into the live digits while paused, so the wrap is reachable quickly.
    task automatic preload_near_wrap();
        @(posedge clk);
        #2;
        force dut.u_min_tens.digit_q = 4'd5;
        force dut.u_min_ones.digit_q = 4'd9;
        force dut.u_sec_tens.digit_q = 4'd5;
        force dut.u_sec_ones.digit_q = 4'd9;
        force dut.u_cs_tens.digit_q  = 4'd9;
        force dut.u_cs_ones.digit_q  = 4'd0;
        @(posedge clk);
        #2;
        release dut.u_min_tens.digit_q;
        release dut.u_min_ones.digit_q;
        release dut.u_sec_tens.digit_q;
        release dut.u_sec_ones.digit_q;
        release dut.u_cs_tens.digit_q;
        release dut.u_cs_ones.digit_q;
        m_live = 359990;
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_vec("outputs", actual_vec(), exp_v);
        end
    end

    initial begin : stimulus
        logic s_r, l_r, c_r, b_r;
        model_reset();
        #23;
        check_vec("reset_values", actual_vec(), RESET_VEC);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check_val("timerenb_after_start", int'(o_timerenb), 1);
        check_val("running_after_start", int'(o_running), 1);
        tick_n(150);
        settle();
        check_disp("run_150_ticks", 150);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(37);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tick_n(20);
        settle();
        check_disp("lap_hold", 37);
        check_val("lap_active", int'(o_lap_active), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check_disp("lap_release", 57);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(500);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(10);
        settle();
        check_disp("pause_hold", 500);
        check_val("timerenb_paused", int'(o_timerenb), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("timer_clr_n_low", int'(o_timer_clr_n), 0);
        check_val("state_after_clear", int'(dbg_state), int'(ST_IDLE));
        check_disp("digits_after_clear", 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_val("timer_clr_n_high", int'(o_timer_clr_n), 1);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("clear_beats_start", int'(dbg_state), int'(ST_IDLE));
        check_disp("clear_beats_start_digits", 0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(9);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        check_val("stop_with_tick_state", int'(dbg_state), int'(ST_PAUSE));
        check_disp("stop_with_tick_digits", 10);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check_val("clear_in_run_ignored", int'(dbg_state), int'(ST_RUN));

        step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        preload_near_wrap();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(9);
        settle();
        check_disp("at_59_59_99", 359999);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check_val("rollover_pulse", int'(o_rollover), 1);
        check_val("running_after_wrap", int'(dbg_state), int'(ST_RUN));
        check_disp("digits_after_wrap", 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_val("rollover_one_cycle", int'(o_rollover), 0);

        for (int i = 0; i < 3000; i++) begin
            s_r = ($urandom_range(0, 19) == 0);
            l_r = ($urandom_range(0, 9) == 0);
            c_r = ($urandom_range(0, 24) == 0);
            b_r = 1'($urandom_range(0, 1));
            step(s_r, l_r, c_r, b_r);
        end
        settle();

        bt = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(1234);
        settle();
        check_disp("run_12_34", 1234);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset_mid_run", actual_vec(), RESET_VEC);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check_val("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
